// File: rtl/sid_audio_pkg.sv
// sid_audio_pkg: shared constants, FSM state type and helpers for the
// SID audio output stage.
//   SAMPLE_W   - mixed sample width (offset binary)
//   SAMPLE_MID - offset-binary midpoint of the mixed sample
//   VOL_W      - master volume width
//   audio_state_t - IDLE -> MUL -> LOAD -> IDLE
//   mid_duty() - midpoint PWM duty for a given PWM resolution
package sid_audio_pkg;

    localparam int unsigned SAMPLE_W   = 15;
    localparam int unsigned SAMPLE_MID = 16384;
    localparam int unsigned VOL_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        LOAD
    } audio_state_t;

    function automatic int unsigned mid_duty(input int unsigned pwm_bits);
        return 32'd1 << (pwm_bits - 1);
    endfunction

endpackage

// File: rtl/sid_audio_out_if.sv
// sid_audio_out_if: sample/volume input and PWM/status output bundle between
// the SID mixer (master) and the audio output stage (slave).
//   sample_in    - mixed sample, offset binary, midpoint 16384
//   sample_valid - high while sample_in holds a finished sample
//   vol          - master volume 0..15
//   mute         - forces midpoint duty
//   pwm_out      - 1-bit PWM audio pin
//   busy         - volume multiply in progress
//   dropped      - pulse: pending duty overwritten before use
interface sid_audio_out_if;
    import sid_audio_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic [VOL_W-1:0]    vol;
    logic                mute;
    logic                pwm_out;
    logic                busy;
    logic                dropped;

    modport master (
        output sample_in, sample_valid, vol, mute,
        input  pwm_out, busy, dropped
    );

    modport slave (
        input  sample_in, sample_valid, vol, mute,
        output pwm_out, busy, dropped
    );

endinterface

// File: rtl/sid_pwm_core.sv
// sid_pwm_core: free-running PWM generator with a double-buffered duty.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_load     - write i_duty into the pending duty register
//   i_duty     - new duty value
//   o_pwm      - registered PWM output, high while counter < active duty
//   o_dropped  - one-cycle pulse when a pending duty is overwritten unused
module sid_pwm_core #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm,
    output logic                o_dropped
);
    import sid_audio_pkg::*;

    localparam logic [PWM_BITS-1:0] DUTY_MID = PWM_BITS'(mid_duty(PWM_BITS));

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_active;
    logic [PWM_BITS-1:0] r_pending;
    logic                r_pend_valid;
    logic                r_pwm;
    logic                r_dropped;
    logic                w_wrap;

    assign w_wrap    = (r_cnt == '1);
    assign o_pwm     = r_pwm;
    assign o_dropped = r_dropped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_active     <= DUTY_MID;
            r_pending    <= DUTY_MID;
            r_pend_valid <= 1'b0;
            r_pwm        <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
            r_pwm <= (r_cnt < r_active);

            // Wrap takes the pending value as it stood before this edge, so a
            // load landing on the wrap cycle stays pending for the next period.
            if (w_wrap && r_pend_valid) begin
                r_active <= r_pending;
            end

            if (i_load) begin
                r_pending    <= i_duty;
                r_pend_valid <= 1'b1;
            end else if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end

            r_dropped <= i_load && r_pend_valid && !w_wrap;
        end
    end

endmodule

// File: rtl/sid_audio_out.sv
// sid_audio_out: captures finished mixer samples, scales them by the 4-bit
// master volume with a sequential shift-add multiplier and feeds the duty
// to a double-buffered PWM core.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - sid_audio_out_if slave: sample_in, sample_valid, vol, mute in;
//                pwm_out, busy, dropped out
// Optional build macro SID_NOISE_SHAPE_EN: first-order error-feedback noise
// shaping of the truncated duty (residual kept across samples).
module sid_audio_out #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned SAMPLE_W = 15
) (
    input logic           clk,
    input logic           rst_n,
    sid_audio_out_if.slave bus
);
    import sid_audio_pkg::*;

    localparam int unsigned S_W    = SAMPLE_W + 1;
    localparam int unsigned ACC_W  = S_W + VOL_W;
    localparam int unsigned SHIFT  = SAMPLE_W - PWM_BITS;
    localparam int unsigned STEP_W = $clog2(VOL_W);
    localparam logic [PWM_BITS-1:0] DUTY_MID = PWM_BITS'(mid_duty(PWM_BITS));

    audio_state_t r_state;
    audio_state_t w_next;

    logic                    r_valid_d;
    logic                    r_cap;
    logic signed [S_W-1:0]   r_s;
    logic [VOL_W-1:0]        r_vol;
    logic signed [ACC_W-1:0] r_acc;
    logic [STEP_W-1:0]       r_step;

    logic                    w_rise;
    logic                    w_cap;
    logic                    w_busy;
    logic                    w_load;
    logic [S_W-1:0]          w_s_new;
    logic signed [ACC_W-1:0] w_s_ext;
    logic signed [S_W-1:0]   w_v;
    logic [S_W-1:0]          w_u;
    logic [PWM_BITS-1:0]     w_duty;
    logic [PWM_BITS-1:0]     w_pend_duty;

    // Edge detect; a capture is only accepted in IDLE and not while the
    // previous capture is still being handed to the FSM.
    assign w_rise  = bus.sample_valid & ~r_valid_d;
    assign w_cap   = w_rise & (r_state == IDLE) & ~r_cap;
    assign w_s_new = {1'b0, bus.sample_in} - S_W'(SAMPLE_MID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_d <= 1'b0;
            r_cap     <= 1'b0;
            r_s       <= '0;
            r_vol     <= '0;
        end else begin
            r_valid_d <= bus.sample_valid;
            r_cap     <= w_cap;
            if (w_cap) begin
                r_s   <= $signed(w_s_new);
                r_vol <= bus.vol;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_cap) w_next = MUL;
            MUL:     if (r_step == STEP_W'(VOL_W - 1)) w_next = LOAD;
            LOAD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy = 1'b0;
        w_load = 1'b0;
        case (r_state)
            MUL:     w_busy = 1'b1;
            LOAD:    w_load = 1'b1;
            default: ;
        endcase
    end

    // Shift-add multiplier: step k adds s<<<k when vol bit k is set.
    assign w_s_ext = {{(ACC_W - S_W){r_s[S_W-1]}}, r_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_step <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_cap) begin
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                MUL: begin
                    if (r_vol[r_step]) begin
                        r_acc <= r_acc + (w_s_ext <<< r_step);
                    end
                    r_step <= r_step + STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // v = p >>> 4 stays within -15360..15359, so u never leaves 15 bits.
    assign w_v = S_W'(r_acc >>> VOL_W);
    assign w_u = w_v + S_W'(SAMPLE_MID);

`ifdef SID_NOISE_SHAPE_EN
    logic [SHIFT-1:0] r_res;
    logic [S_W-1:0]   w_un;
    logic [S_W-1:0]   w_us;

    assign w_un   = w_u + S_W'(r_res);
    assign w_us   = (w_un > {1'b0, {SAMPLE_W{1'b1}}}) ? {1'b0, {SAMPLE_W{1'b1}}} : w_un;
    assign w_duty = PWM_BITS'(w_us >> SHIFT);

    // Residual carries the truncated LSBs into the next sample; a muted
    // load leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else if (w_load && !bus.mute) begin
            r_res <= w_us[SHIFT-1:0];
        end
    end
`else
    assign w_duty = PWM_BITS'(w_u >> SHIFT);
`endif

    assign w_pend_duty = bus.mute ? DUTY_MID : w_duty;
    assign bus.busy    = w_busy;

    sid_pwm_core #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_duty   (w_pend_duty),
        .o_pwm    (bus.pwm_out),
        .o_dropped(bus.dropped)
    );

endmodule

// File: doc/sid_audio_out.md
Name: sid_audio_out

Overview:
- Downstream stage of the SID voice/filter mixer.
- Captures each finished 15-bit mixed sample, which is offset-binary with a midpoint of 16384.
- Applies the 4-bit master volume with a sequential shift-add multiplier.
- Drives a double-buffered, free-running 1-bit PWM audio pin that feeds the external RC reconstruction filter.

Parameters:
- PWM_BITS, 8, PWM counter and duty resolution (legal range 4..12).
- SAMPLE_W, 15, input sample width. Fixed; present only for package/width checks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_in  in  15  mixed sample from the mixer/filter, offset binary, midpoint 16384
- sample_valid  in  1  high while sample_in holds a finished sample; may stay high for many clk cycles
- vol  in  4  master volume, 0..15
- mute  in  1  forces midpoint duty
- pwm_out  out  1  PWM audio output
- busy  out  1  volume multiply in progress
- dropped  out  1  one-cycle pulse: a pending duty was overwritten before it was used

Behaviour:
- Reset is asynchronous on rst_n low. All state clears:
  - pwm counter = 0, active duty = midpoint M = 2^(PWM_BITS-1), pending duty = M, pending_valid = 0
  - pwm_out = 0, busy = 0, dropped = 0, FSM = IDLE
  - noise-shaping residual = 0
- Reset asserted mid-multiply aborts the multiply; no partial result is loaded.
- Capture: detect the rising edge of sample_valid, using a registered copy of it.
  - On the edge, register s = sample_in − 16384 as a 16-bit signed value, and latch vol.
  - A level held high for many cycles yields exactly one capture.
- FSM states are IDLE → MUL → LOAD → IDLE.
  - IDLE: on a capture, clear the accumulator and go to MUL; busy = 1.
  - MUL: 4 cycles; step k adds (s <<< k) when vol_latched[k] = 1.
  - LOAD: compute duty and write it to the pending register, then go to IDLE; busy = 0.
  - Total latency from the capture edge to the pending write is 6 clk cycles.
  - A rising edge of sample_valid while not in IDLE is ignored. Upstream cadence guarantees this never occurs legitimately.
- Arithmetic:
  - Product p = s*vol, 20-bit signed.
  - Scaled value v = p >>> 4 (arithmetic shift), range −15360..15359, so clamping is never needed.
  - u = v + 16384, 15-bit unsigned.
  - duty = u >> (15 − PWM_BITS).
- mute = 1 in LOAD writes M to the pending register instead of the computed duty.
- PWM counter:
  - Increments every clk and wraps from 2^PWM_BITS − 1 to 0.
  - pwm_out is registered: pwm_out <= (counter < active_duty).
  - duty 0 gives constant 0; the maximum duty 2^PWM_BITS − 1 gives high for all but one count.
- Double buffer:
  - On the wrap cycle, active_duty <= pending duty if pending_valid, and pending_valid clears.
  - A LOAD while pending_valid = 1 overwrites the pending duty and pulses dropped.
  - A LOAD on the same cycle as the wrap: the wrap transfers the old pending value, the new value becomes pending, and dropped does not pulse.

Optional Feature:
- SID_NOISE_SHAPE_EN defined: first-order error feedback.
  - In LOAD, u' = u + r (16-bit), saturated at 32767.
  - duty = u' >> (15 − PWM_BITS).
  - r <= low (15 − PWM_BITS) bits of u'.
  - r clears on reset; it is not updated when mute = 1.
- Undefined: plain truncation; no residual register exists.

Decomposition:
- Package sid_audio_pkg holds:
  - SAMPLE_W = 15, SAMPLE_MID = 16384, VOL_W = 4
  - FSM state enum {IDLE, MUL, LOAD}
  - a function computing midpoint duty from PWM_BITS
- Sub-module sid_pwm_core holds the counter, active/pending duty registers, wrap transfer, dropped generation and pwm_out register.
- Top level holds edge detect, FSM, multiplier and optional noise shaping.

Test Plan:
All scenarios use PWM_BITS = 8 with the feature undefined unless stated.
1. After reset release: pwm_out high for 128 of every 256 cycles; busy = 0, dropped = 0.
2. sample_in = 28669, vol = 15, one rising edge → pending = 217 six cycles later; from the next wrap, pwm_out is high for 217/256 cycles.
3. sample_in = 28669, vol = 0 → duty 128. sample_in = 0, vol = 15 → v = −15360, duty 8.
4. sample_valid held high for 100 cycles with a changing sample_in → exactly one capture; duty reflects the value at the edge only.
5. Two captures spaced 20 cycles apart within one PWM period → dropped pulses once; only the second duty is applied at the wrap. mute = 1 during a LOAD → duty 128.
6. rst_n low for 1 cycle during MUL → all outputs at reset values immediately; the next capture is processed normally. With SID_NOISE_SHAPE_EN, u = 16448 repeated → duty alternates between 128 and 129, averaging 128.5 over 2 samples.
